// File: rtl/ahbl_cmd_master.sv
// AHB-Lite single-transfer master: turns a valid/ready command stream into
// pipelined NONSEQ transfers with one in-order response per command.
module ahbl_cmd_master #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,

  output logic        rsp_valid,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        aph_valid;
  logic        aph_err;
  logic [31:0] aph_wdata;

  logic        dph_valid;
  logic        dph_write;
  logic        dph_err;
  logic [31:0] dph_wdata;

  logic        cmd_misaligned;
  logic        cmd_err;
  logic        accept;
  logic        aph_done;
  logic        dph_done;

  always_comb begin
    cmd_misaligned = 1'b0;
    case (cmd_size)
      3'd0:    cmd_misaligned = 1'b0;
      3'd1:    cmd_misaligned = cmd_addr[0];
      3'd2:    cmd_misaligned = |cmd_addr[1:0];
      default: cmd_misaligned = 1'b1;
    endcase
  end

  assign cmd_err   = ERR_ON_MISALIGN & cmd_misaligned;
  assign cmd_ready = ~aph_valid | HREADY;
  assign accept    = cmd_valid & cmd_ready;
  assign aph_done  = aph_valid & HREADY;
  assign dph_done  = dph_valid & HREADY;
  assign busy      = aph_valid | dph_valid;
  assign HWDATA    = dph_wdata;

  // Address slot; a rejected command rides along with HTRANS kept IDLE so
  // that its error response stays in order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_valid <= 1'b0;
      aph_err   <= 1'b0;
      aph_wdata <= '0;
      HADDR     <= '0;
      HSIZE     <= '0;
      HWRITE    <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
    end else if (accept) begin
      aph_valid <= 1'b1;
      aph_err   <= cmd_err;
      aph_wdata <= cmd_wdata;
      HADDR     <= cmd_addr;
      HSIZE     <= cmd_size;
      HWRITE    <= cmd_write;
      HTRANS    <= cmd_err ? HTRANS_IDLE : HTRANS_NONSEQ;
    end else if (aph_done) begin
      aph_valid <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_err   <= 1'b0;
      dph_wdata <= '0;
    end else if (aph_done) begin
      dph_valid <= 1'b1;
      dph_write <= HWRITE;
      dph_err   <= aph_err;
      dph_wdata <= aph_wdata;
    end else if (dph_done) begin
      dph_valid <= 1'b0;
    end
  end

  // Response fields are zero whenever no response is being presented.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dph_done;
      rsp_write <= dph_done & dph_write;
      rsp_err   <= dph_done & dph_err;
      rsp_rdata <= (dph_done && !dph_write && !dph_err) ? HRDATA : 32'h0;
    end
  end

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Directed self-checking bench for ahbl_cmd_master; inputs change on the
// falling edge and outputs are checked 1 time unit later.
module tb_ahbl_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  ahbl_cmd_master #(.ERR_ON_MISALIGN(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
  endtask

  task automatic next_cycle();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1; HRDATA = 32'hFFFF_FFFF;
    set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    repeat (3) next_cycle();
    HRESETn = 1'b1;
    #1;
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans: got %b expected 00", HTRANS); end
    checks++; if (HADDR !== 32'h0 || HSIZE !== 3'd0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: got addr %h size %0d write %b wdata %h expected all 0", HADDR, HSIZE, HWRITE, HWDATA); end
    checks++; if ({rsp_valid, rsp_write, rsp_err, busy} !== 4'b0000 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp: got v%b w%b e%b busy%b rdata %h expected all 0", rsp_valid, rsp_write, rsp_err, busy, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0000_0000, 3'd2, 32'hDEAD_BEEF); #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_accept: got ready %b busy %b expected 1 0", cmd_ready, busy); end
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin errors++; $display("[TB] FAIL wr_aphase: got trans %b addr %h write %b size %0d expected 10 0 1 2", HTRANS, HADDR, HWRITE, HSIZE); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy: got %b expected 1", busy); end
    next_cycle(); #1;
    checks++; if (HWDATA !== 32'hDEAD_BEEF || HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_dphase: got wdata %h trans %b rsp %b expected deadbeef 00 0", HWDATA, HTRANS, rsp_valid); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rsp: got v%b w%b e%b rdata %h expected v1 w1 e0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle: got busy %b expected 0", busy); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_pulse: got rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_single_read();
    next_cycle(); set_cmd(1'b1, 1'b0, 32'h0100_0000, 3'd2, 32'h5555_5555);
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0100_0000 || HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL rd_aphase: got trans %b addr %h write %b expected 10 01000000 0", HTRANS, HADDR, HWRITE); end
    next_cycle(); HRDATA = 32'h1234_5678;
    next_cycle(); HRDATA = 32'hFFFF_FFFF; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_rsp: got v%b w%b e%b rdata %h expected v1 w0 e0 12345678", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_pulse: got rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0000_0000, 3'd2, 32'hA0A0_A0A0);
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0100_0000, 3'd2, 32'hB1B1_B1B1); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c1: got trans %b addr %h ready %b expected 10 0 1", HTRANS, HADDR, cmd_ready); end
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0200_0000, 3'd2, 32'hC2C2_C2C2); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0100_0000 || HWDATA !== 32'hA0A0_A0A0) begin errors++; $display("[TB] FAIL b2b_c2: got trans %b addr %h wdata %h expected 10 01000000 a0a0a0a0", HTRANS, HADDR, HWDATA); end
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0200_0000 || HWDATA !== 32'hB1B1_B1B1 || rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c3: got trans %b addr %h wdata %h rsp %b expected 10 02000000 b1b1b1b1 1", HTRANS, HADDR, HWDATA, rsp_valid); end
    next_cycle(); #1;
    checks++; if (HTRANS !== 2'b00 || HWDATA !== 32'hC2C2_C2C2 || rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c4: got trans %b wdata %h rsp %b expected 00 c2c2c2c2 1", HTRANS, HWDATA, rsp_valid); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin errors++; $display("[TB] FAIL b2b_c5: got rsp %b write %b expected 1 1", rsp_valid, rsp_write); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_c6: got rsp %b busy %b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_wait_states();
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0000_0000, 3'd2, 32'hA0A0_A0A0);
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0100_0000, 3'd2, 32'hB1B1_B1B1);
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0200_0000, 3'd2, 32'hC2C2_C2C2);
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); HREADY = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b0 || HADDR !== 32'h0200_0000 || HTRANS !== 2'b10 || HWDATA !== 32'hB1B1_B1B1) begin errors++; $display("[TB] FAIL ws_stall1: got ready %b addr %h trans %b wdata %h expected 0 02000000 10 b1b1b1b1", cmd_ready, HADDR, HTRANS, HWDATA); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ws_rsp1: got %b expected 1", rsp_valid); end
    next_cycle(); #1;
    checks++; if (cmd_ready !== 1'b0 || HADDR !== 32'h0200_0000 || HTRANS !== 2'b10 || HWDATA !== 32'hB1B1_B1B1 || HSIZE !== 3'd2 || HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL ws_stall2: got ready %b addr %h trans %b wdata %h expected 0 02000000 10 b1b1b1b1", cmd_ready, HADDR, HTRANS, HWDATA); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_norsp2: got %b expected 0", rsp_valid); end
    next_cycle(); HREADY = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1 || HADDR !== 32'h0200_0000 || HWDATA !== 32'hB1B1_B1B1 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_release: got ready %b addr %h wdata %h rsp %b expected 1 02000000 b1b1b1b1 0", cmd_ready, HADDR, HWDATA, rsp_valid); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b1 || HWDATA !== 32'hC2C2_C2C2 || HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL ws_rsp2: got rsp %b wdata %h trans %b expected 1 c2c2c2c2 00", rsp_valid, HWDATA, HTRANS); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ws_rsp3: got %b expected 1", rsp_valid); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ws_done: got rsp %b busy %b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_misalign();
    next_cycle(); set_cmd(1'b1, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
    next_cycle(); set_cmd(1'b1, 1'b0, 32'h0000_0002, 3'd2, 32'h0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0010) begin errors++; $display("[TB] FAIL mis_first: got trans %b addr %h expected 10 00000010", HTRANS, HADDR); end
    next_cycle(); set_cmd(1'b1, 1'b0, 32'h0000_0020, 3'd2, 32'h0); HRDATA = 32'h1111_AAAA; #1;
    checks++; if (HTRANS !== 2'b00 || busy !== 1'b1) begin errors++; $display("[TB] FAIL mis_idle: got trans %b busy %b expected 00 1", HTRANS, busy); end
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); HRDATA = 32'hCAFE_CAFE; #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0020) begin errors++; $display("[TB] FAIL mis_third: got trans %b addr %h expected 10 00000020", HTRANS, HADDR); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1111_AAAA) begin errors++; $display("[TB] FAIL mis_rsp_ok1: got v%b e%b rdata %h expected v1 e0 1111aaaa", rsp_valid, rsp_err, rsp_rdata); end
    next_cycle(); HRDATA = 32'h2222_BBBB; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mis_rsp_err: got v%b e%b w%b rdata %h expected v1 e1 w0 0", rsp_valid, rsp_err, rsp_write, rsp_rdata); end
    next_cycle(); HRDATA = 32'hFFFF_FFFF; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h2222_BBBB) begin errors++; $display("[TB] FAIL mis_rsp_ok2: got v%b e%b rdata %h expected v1 e0 2222bbbb", rsp_valid, rsp_err, rsp_rdata); end
    next_cycle(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_done: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0000_0040, 3'd2, 32'h1111_1111);
    next_cycle(); set_cmd(1'b1, 1'b1, 32'h0000_0044, 3'd2, 32'h2222_2222);
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); HREADY = 1'b0; #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0044 || HWDATA !== 32'h1111_1111) begin errors++; $display("[TB] FAIL rst_pre: got trans %b addr %h wdata %h expected 10 00000044 11111111", HTRANS, HADDR, HWDATA); end
    next_cycle(); HRESETn = 1'b0; #1;
    checks++; if (HTRANS !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL rst_async: got trans %b busy %b rsp %b addr %h wdata %h expected 00 0 0 0 0", HTRANS, busy, rsp_valid, HADDR, HWDATA); end
    next_cycle(); HRESETn = 1'b1; HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_dropped_%0d: got rsp %b busy %b expected 0 0", i, rsp_valid, busy); end
    end
    next_cycle(); set_cmd(1'b1, 1'b0, 32'h0000_0080, 3'd2, 32'h0);
    next_cycle(); set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0080) begin errors++; $display("[TB] FAIL rst_after_aphase: got trans %b addr %h expected 10 00000080", HTRANS, HADDR); end
    next_cycle(); HRDATA = 32'h0BAD_F00D;
    next_cycle(); HRDATA = 32'hFFFF_FFFF; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL rst_after_rsp: got v%b e%b rdata %h expected v1 e0 0badf00d", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_misalign();
    test_reset_midflight();
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_cmd_master.md
Name: ahbl_cmd_master

Overview:
- AHB-Lite single-transfer master that sits directly upstream of the register slaves on the TinyML SoC bus.
- Converts a simple valid/ready command stream (from the test sequencer or a control FSM) into pipelined AHB-Lite NONSEQ transfers.
- Honours HREADY wait states and returns one in-order response per command.
- Address and data phases overlap, so back-to-back commands sustain one transfer per cycle with zero-wait slaves.

Parameters:
- ERR_ON_MISALIGN, 1: 1 = misaligned command is not issued on the bus and is reported with rsp_err; 0 = issued unchanged.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted at edge when cmd_valid&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_size  in  3  HSIZE encoding (0 = byte, 1 = half, 2 = word; 3..7 treated as misaligned)
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_write  out  1  response belongs to a write
- rsp_err  out  1  command was rejected (misaligned)
- rsp_rdata  out  32  read data (0 for writes and errors)
- busy  out  1  address or data phase outstanding
- HADDR  out  32  AHB address
- HTRANS  out  2  00 IDLE or 10 NONSEQ only
- HSIZE  out  3  AHB size
- HWRITE  out  1  AHB direction
- HWDATA  out  32  AHB write data
- HREADY  in  1  bus ready (slave HREADYOUT)
- HRDATA  in  32  read data

Behaviour:
- Reset values:
  - HTRANS=00; HADDR, HSIZE, HWRITE and HWDATA = 0.
  - rsp_valid, rsp_write, rsp_err, rsp_rdata = 0; busy=0.
  - Both pipeline slots are empty.
- Reset asserted mid-transfer: all slots are dropped, no response is ever produced for in-flight commands, and HTRANS goes IDLE asynchronously.
- Address slot (aph) and data slot (dph) hold the state; all AHB outputs are driven from registers.
- cmd_ready = ~aph_valid | HREADY. It is combinational and depends on HREADY only when aph is full.
- Command accept (edge with cmd_valid&cmd_ready):
  - aph loads addr, size and write; its wdata is held for the data phase.
  - Next cycle: HTRANS=NONSEQ, HADDR=cmd_addr, HSIZE=cmd_size, HWRITE=cmd_write.
- Misalignment (ERR_ON_MISALIGN=1): a command is misaligned when size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or size>2.
  - The command still occupies aph, but HTRANS=IDLE for that slot.
  - A tag marks it as an error; the slot flows through the pipeline so response order is preserved.
- Address phase completes at an edge with aph_valid&HREADY:
  - dph loads write, err and wdata.
  - aph is refilled from the same-edge command if one is accepted, otherwise aph empties and HTRANS=IDLE.
- HWDATA = dph.wdata throughout the data phase and stays stable while HREADY=0.
- While HREADY=0, HADDR, HTRANS, HSIZE and HWRITE hold their values; a pending NONSEQ is never withdrawn.
- Data phase completes at an edge with dph_valid&HREADY:
  - rsp_valid=1 in the following cycle for exactly one cycle.
  - rsp_rdata = HRDATA sampled at that edge for non-error reads, else 0.
  - rsp_write = dph.write; rsp_err = dph.err.
- Latency with zero-wait slaves: command accepted at edge E0, address phase E0..E1, data phase E1..E2, rsp_valid high E2..E3. Each wait cycle adds one cycle.
- Throughput: commands held valid continuously give one transfer per cycle with zero waits.
- Simultaneous address completion, data completion and new accept at one edge is legal: all three slot moves occur together.
- Responses leave in strict command order.
- busy = aph_valid | dph_valid.
- No HBURST, HPROT or locked transfers; HRESP is not monitored, since the slaves always return OKAY.

Test Plan:
- Write 0x0000_0000 with 0xDEADBEEF, size 2, HREADY tied 1:
  - HTRANS=10 with HADDR=0 one cycle after accept.
  - HWDATA=0xDEADBEEF the next cycle.
  - rsp_valid with rsp_write=1, rsp_err=0 two cycles after accept.
- Read 0x0100_0000 where the model returns HRDATA=0x1234_5678 in the data phase -> rsp_rdata=0x12345678, rsp_write=0, one pulse.
- Three back-to-back writes to 0x0000_0000, 0x0100_0000 and 0x0200_0000 with zero waits:
  - HTRANS=10 for three consecutive cycles, HWDATA lagging by one cycle.
  - Three consecutive rsp_valid pulses.
- Same three writes with HREADY held 0 for 2 cycles during the second data phase:
  - HADDR=0x0200_0000 and HWDATA of the second write are held stable.
  - cmd_ready=0 during the stall; responses arrive in order.
- Read addr 0x0000_0002 size 2 between two valid reads:
  - Bus shows IDLE in that slot.
  - Responses arrive as ok, err (rdata=0), ok, in order.
- HRESETn pulsed low during a wait-stated data phase:
  - HTRANS=00 immediately and no rsp_valid for the dropped command.
  - A new command after release completes normally.
